// File: rtl/backup_mem_pkg.sv
// Shared types and helpers for the block-oriented backup memory.
package backup_mem_pkg;

  // Transfer engine states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } state_t;

  // Ceiling log2, used for beat counter, RAM index and FIFO pointer widths.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/param_backup_memory_if.sv
// Request, write-data and read-response channels of the backup memory.
interface param_backup_memory_if #(
  parameter int ADDR_BITS = 26,
  parameter int TAG_BITS  = 5,
  parameter int DATA_BITS = 128
) ();

  logic                 req_valid;
  logic                 req_ready;
  logic                 req_rw;
  logic [ADDR_BITS-1:0] req_addr;
  logic [TAG_BITS-1:0]  req_tag;
  logic                 data_valid;
  logic                 data_ready;
  logic [DATA_BITS-1:0] data_bits;
  logic                 resp_valid;
  logic                 resp_ready;
  logic [DATA_BITS-1:0] resp_data;
  logic [TAG_BITS-1:0]  resp_tag;
  logic                 resp_last;

  // Requester side: issues requests and write beats, consumes read beats.
  modport master (
    output req_valid, req_rw, req_addr, req_tag, data_valid, data_bits, resp_ready,
    input  req_ready, data_ready, resp_valid, resp_data, resp_tag, resp_last
  );

  // Memory side.
  modport slave (
    input  req_valid, req_rw, req_addr, req_tag, data_valid, data_bits, resp_ready,
    output req_ready, data_ready, resp_valid, resp_data, resp_tag, resp_last
  );

endinterface

// File: rtl/backup_mem_req_fifo.sv
// Synchronous request FIFO; pointers carry one extra wrap bit for full/empty.
module backup_mem_req_fifo
  import backup_mem_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_BITS = clog2(DEPTH);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [PTR_BITS:0] wr_ptr_reg;
  logic [PTR_BITS:0] rd_ptr_reg;
  logic              do_push;
  logic              do_pop;

  assign empty    = (wr_ptr_reg == rd_ptr_reg);
  assign full     = (wr_ptr_reg[PTR_BITS] != rd_ptr_reg[PTR_BITS]) &&
                    (wr_ptr_reg[PTR_BITS-1:0] == rd_ptr_reg[PTR_BITS-1:0]);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr_reg[PTR_BITS-1:0]];

  // Pointer update; push is gated only by full, never by a same-cycle pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  // Entry storage.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg[PTR_BITS-1:0]] <= push_data;
  end

endmodule

// File: rtl/param_backup_memory.sv
// Block backup memory: queued read/write requests, DATA_CYCLES beats per block.
module param_backup_memory
  import backup_mem_pkg::*;
#(
  parameter int ADDR_BITS       = 26,
  parameter int TAG_BITS        = 5,
  parameter int DATA_BITS       = 128,
  parameter int DATA_CYCLES     = 4,
  parameter int DEPTH           = 2097152,
  parameter int REQ_QUEUE_DEPTH = 4
) (
  input logic                  clk,
  input logic                  reset,
  param_backup_memory_if.slave bus
);

  localparam int CNT_BITS = clog2(DATA_CYCLES);
  localparam int BLK_BITS = clog2(DEPTH / DATA_CYCLES);
  localparam int IDX_BITS = BLK_BITS + CNT_BITS;
  localparam int REQ_BITS = 1 + ADDR_BITS + TAG_BITS;
  localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(DATA_CYCLES - 1);

  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 fifo_pop;
  logic [REQ_BITS-1:0]  head;
  logic                 head_rw;
  logic [ADDR_BITS-1:0] head_addr;
  logic [TAG_BITS-1:0]  head_tag;
  logic                 unused_head_addr;

  state_t               state_reg, state_next;
  logic [CNT_BITS-1:0]  cnt_reg, cnt_next;
  logic [BLK_BITS-1:0]  blk_reg;
  logic [TAG_BITS-1:0]  tag_reg;
  logic                 resp_valid_reg, resp_valid_next;
  logic                 resp_last_reg;
  logic [DATA_BITS-1:0] resp_data_reg;
  logic [TAG_BITS-1:0]  resp_tag_reg;
  logic                 issue;
  logic                 ram_we;
  logic                 wr_ready;
  logic [IDX_BITS-1:0]  ram_index;

  // Zero at configuration time only; reset leaves the contents alone.
  logic [DATA_BITS-1:0] ram [DEPTH] = '{default: '0};

  backup_mem_req_fifo #(
    .WIDTH (REQ_BITS),
    .DEPTH (REQ_QUEUE_DEPTH)
  ) u_req_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (bus.req_valid),
    .push_data ({bus.req_rw, bus.req_addr, bus.req_tag}),
    .pop       (fifo_pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign head_rw   = head[REQ_BITS-1];
  assign head_addr = head[TAG_BITS +: ADDR_BITS];
  assign head_tag  = head[TAG_BITS-1:0];
  // Address bits above the block index alias onto the same RAM block.
  assign unused_head_addr = ^head_addr;

  assign ram_index       = {blk_reg, cnt_reg};
  assign bus.req_ready   = !fifo_full;
  assign bus.data_ready  = wr_ready;
  assign bus.resp_valid  = resp_valid_reg;
  assign bus.resp_last   = resp_last_reg;
  assign bus.resp_data   = resp_data_reg;
  assign bus.resp_tag    = resp_tag_reg;

  // Engine next-state: pop in IDLE, issue read beats into a one-deep output stage, accept write beats.
  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    fifo_pop        = 1'b0;
    issue           = 1'b0;
    ram_we          = 1'b0;
    wr_ready        = 1'b0;
    resp_valid_next = resp_valid_reg && !bus.resp_ready;
    case (state_reg)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          state_next = head_rw ? WRITE : READ;
        end
      end
      READ: begin
        if (!resp_valid_reg || bus.resp_ready) begin
          issue           = 1'b1;
          resp_valid_next = 1'b1;
          cnt_next        = cnt_reg + 1'b1;
          if (cnt_reg == CNT_LAST) state_next = IDLE;
        end
      end
      WRITE: begin
        wr_ready = 1'b1;
        if (bus.data_valid) begin
          ram_we   = 1'b1;
          cnt_next = cnt_reg + 1'b1;
          if (cnt_reg == CNT_LAST) state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Control state; reset abandons any block in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      resp_valid_reg <= 1'b0;
      resp_last_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      resp_valid_reg <= resp_valid_next;
      if (issue) resp_last_reg <= (cnt_reg == CNT_LAST);
    end
  end

  // Latch the popped request's block index and tag.
  always_ff @(posedge clk) begin
    if (fifo_pop) begin
      blk_reg <= head_addr[BLK_BITS-1:0];
      tag_reg <= head_tag;
    end
  end

  // RAM write port and registered read into the response stage.
  always_ff @(posedge clk) begin
    if (ram_we) ram[ram_index] <= bus.data_bits;
    if (issue) begin
      resp_data_reg <= ram[ram_index];
      resp_tag_reg  <= tag_reg;
    end
  end

endmodule

// File: doc/param_backup_memory.md
PARAM_BACKUP_MEMORY -- requirements
Module: param_backup_memory

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 26, width of request block address.
REQ-002 SHALL have parameter TAG_BITS, default 5, width of request/response tag.
REQ-003 SHALL have parameter DATA_BITS, default 128, width of one data beat.
REQ-004 SHALL have parameter DATA_CYCLES, default 4, beats per block; power of two, at least 2.
REQ-005 SHALL have parameter DEPTH, default 2097152, RAM words; power of two, multiple of DATA_CYCLES.
REQ-006 SHALL have parameter REQ_QUEUE_DEPTH, default 4, request FIFO entries; power of two, at least 2.
REQ-007 SHALL have ports (clock and reset first):
 clk  in  1  clock; all logic on rising edge
 reset  in  1  synchronous, active-high reset
 req_valid  in  1  request offered
 req_ready  out  1  request FIFO not full
 req_rw  in  1  1=write, 0=read
 req_addr  in  ADDR_BITS  block address
 req_tag  in  TAG_BITS  request tag
 data_valid  in  1  write beat offered
 data_ready  out  1  write beat accepted when high with data_valid
 data_bits  in  DATA_BITS  write beat
 resp_valid  out  1  read beat valid
 resp_ready  in  1  consumer accepts read beat
 resp_data  out  DATA_BITS  read beat
 resp_tag  out  TAG_BITS  tag of the owning read
 resp_last  out  1  final beat of the block

Function
REQ-008 Request handshake SHALL be req_valid&&req_ready; accepted {rw,addr,tag} pushed into the FIFO; req_ready = !full, independent of same-cycle pop.
REQ-009 Engine SHALL have states IDLE, READ, WRITE; IDLE with FIFO non-empty pops head, latches it, goes to READ or WRITE per rw.
REQ-010 RAM index SHALL be {addr[log2(DEPTH/DATA_CYCLES)-1:0], cnt}; upper address bits ignored (aliasing); cnt is log2(DATA_CYCLES) bits.
REQ-011 In READ, a beat SHALL issue when !resp_valid||resp_ready; issue loads resp_data=ram[index], resp_tag, resp_last=(cnt==DATA_CYCLES-1), asserts resp_valid next cycle, increments cnt.
REQ-012 resp_valid/resp_data/resp_tag/resp_last SHALL hold stable while resp_valid&&!resp_ready.
REQ-013 resp_valid SHALL deassert after an accepted beat when no new beat issues that cycle.
REQ-014 In WRITE, data_ready SHALL be 1; each data_valid&&data_ready writes data_bits to ram[index], increments cnt; data_ready SHALL be 0 in IDLE and READ.
REQ-015 After the last beat issues/writes (cnt wraps to 0), engine SHALL return to IDLE; next head pops no earlier than the following cycle.
REQ-016 Latency: request accepted cycle 0 into empty FIFO, idle engine -> pop cycle 1, READ cycle 2, first resp_valid cycle 3; with resp_ready=1 beats are back-to-back.
REQ-017 Requests SHALL complete strictly in acceptance order; a write beat never overtakes an earlier read.
REQ-018 Data beats presented outside WRITE SHALL be ignored (not consumed).
REQ-019 RAM SHALL be zero-initialised at time 0 only.

Reset
REQ-020 Reset SHALL clear FIFO to empty, state to IDLE, cnt to 0, resp_valid and resp_last to 0; req_ready=1 and data_ready=0 the cycle after reset.
REQ-021 Reset mid-transfer SHALL abandon the block: queued requests dropped, partially written beats remain in RAM, RAM otherwise preserved.
REQ-022 resp_data and resp_tag need no reset value.

Structure
REQ-023 Package backup_mem_pkg SHALL hold the state enum and a ceil-log2 function used for cnt, index and FIFO pointer widths.
REQ-024 Request FIFO SHALL be sub-module backup_mem_req_fifo (synchronous, width 1+ADDR_BITS+TAG_BITS, depth REQ_QUEUE_DEPTH).

Verification
REQ-025 Write addr 0x10, beats A0..A3, then read 0x10 with resp_ready=1 -> 4 beats A0..A3 on consecutive cycles, tag matches, resp_last on beat 4 only.
REQ-026 Read with resp_ready low cycles 4-6 -> beat 0 held stable, no beat lost or duplicated, totals 4 beats.
REQ-027 Five reads, tags 1..5, offered back-to-back while engine stalled -> req_ready low on 5th until a pop; responses in tag order 1..5.
REQ-028 Write to addr 0x10 and to 0x10+DEPTH/DATA_CYCLES, read 0x10 -> returns second block's data (aliasing).
REQ-029 Reset asserted after 2 write beats -> FIFO empty, state IDLE; read of that block returns 2 new beats then 2 zero beats.
REQ-030 data_valid pulsed during READ -> data_ready 0, RAM unchanged.
